// File: rtl/keccak_msg_sequencer.sv
// keccak_msg_sequencer
//
// Streams one message at a time from an upstream word interface into a
// Keccak core, then collects DIGEST_WORDS output words from the core into a
// local buffer and drains them downstream with valid/ready handshaking.
//
// Parameters
//   W              width of message and digest words
//   DIGEST_WORDS   number of core output words collected per message (1..8)
//   TIMEOUT_CYCLES watchdog limit (max 65535), only with KECCAK_SEQ_TIMEOUT_EN
//
// Optional feature macro
//   KECCAK_SEQ_TIMEOUT_EN  enables a 16-bit watchdog over WAIT_READY+COLLECT.
//                          When undefined, err is tied 0 and the sequencer
//                          waits on the core indefinitely.
//
// Ports
//   clk, rst                 single clock, synchronous active-high reset
//   s_data/s_valid/s_end     upstream message words; s_end marks the
//   s_ready                  terminator beat (its s_data is ignored)
//   core_start               one-cycle start pulse to the core
//   core_din/core_din_valid  message words forwarded to the core
//   core_last_block          one-cycle pulse once the message is complete
//   core_buffer_full         core input backpressure
//   core_ready               core idle and able to take the last-block pulse
//   core_dout/_valid         digest words from the core
//   m_data/m_valid/m_ready   downstream digest words, m_last on the final one
//   busy                     high in every state except IDLE
//   done                     one-cycle pulse on the final digest handshake
//   msg_count                completed messages, wraps at 16 bits
//   err                      sticky watchdog timeout flag

module keccak_msg_sequencer #(
    parameter int W              = 64,
    parameter int DIGEST_WORDS   = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,

    input  logic [W-1:0]  s_data,
    input  logic          s_valid,
    input  logic          s_end,
    output logic          s_ready,

    output logic          core_start,
    output logic [W-1:0]  core_din,
    output logic          core_din_valid,
    output logic          core_last_block,
    input  logic          core_buffer_full,
    input  logic          core_ready,
    input  logic [W-1:0]  core_dout,
    input  logic          core_dout_valid,

    output logic [W-1:0]  m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          m_last,

    output logic          busy,
    output logic          done,
    output logic [15:0]   msg_count,
    output logic          err
);

    localparam int IDX_W = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGEST_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        GAP        = 3'd2,
        FEED       = 3'd3,
        WAIT_READY = 3'd4,
        LAST       = 3'd5,
        COLLECT    = 3'd6,
        DRAIN      = 3'd7
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [W-1:0]     digest_buf [DIGEST_WORDS];

    logic capture;
    logic last_capture;
    logic end_accept;
    logic rd_is_last;
    logic final_fire;
    logic timeout;

    assign capture      = (state == COLLECT) && core_dout_valid;
    assign last_capture = capture && (wr_idx == IDX_LAST);
    // The terminator beat is consumed like any other beat but never reaches the core.
    assign end_accept   = (state == FEED) && s_valid && !core_buffer_full && s_end;
    assign rd_is_last   = (rd_idx == IDX_LAST);
    assign final_fire   = (state == DRAIN) && m_ready && rd_is_last;

`ifdef KECCAK_SEQ_TIMEOUT_EN
    logic [15:0] wd_count;
    logic        err_flag;
    logic        wd_active;

    assign wd_active = (state == WAIT_READY) || (state == COLLECT);
    assign timeout   = wd_active && (wd_count == 16'(TIMEOUT_CYCLES - 1));
    assign err       = err_flag;

    // Watchdog restarts on every entry to WAIT_READY and holds through LAST,
    // so it measures the whole wait-for-core plus collect window.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_count <= '0;
            err_flag <= 1'b0;
        end else begin
            if (state != WAIT_READY && state_next == WAIT_READY) begin
                wd_count <= '0;
            end else if (wd_active) begin
                wd_count <= wd_count + 16'd1;
            end
            if (timeout) begin
                err_flag <= 1'b1;
            end
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (s_valid) state_next = START;
            START:      state_next = GAP;
            GAP:        state_next = FEED;
            FEED:       if (end_accept) state_next = WAIT_READY;
            WAIT_READY: begin
                if (timeout)                             state_next = IDLE;
                else if (core_ready && !core_buffer_full) state_next = LAST;
            end
            LAST:       state_next = COLLECT;
            COLLECT: begin
                if (timeout)           state_next = IDLE;
                else if (last_capture) state_next = DRAIN;
            end
            DRAIN:      if (final_fire) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    // Outputs; forced low while rst is high so nothing leaks from an aborted state.
    always_comb begin
        s_ready         = 1'b0;
        core_start      = 1'b0;
        core_din        = '0;
        core_din_valid  = 1'b0;
        core_last_block = 1'b0;
        m_valid         = 1'b0;
        m_data          = '0;
        m_last          = 1'b0;
        busy            = 1'b0;
        done            = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                START: core_start = 1'b1;
                FEED: begin
                    s_ready        = !core_buffer_full;
                    core_din       = s_data;
                    core_din_valid = s_valid && !core_buffer_full && !s_end;
                end
                LAST:  core_last_block = 1'b1;
                DRAIN: begin
                    m_valid = 1'b1;
                    m_data  = digest_buf[rd_idx];
                    m_last  = rd_is_last;
                    done    = m_ready && rd_is_last;
                end
                default: ;
            endcase
        end
    end

    // Indices and message counter
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_idx    <= '0;
            rd_idx    <= '0;
            msg_count <= '0;
        end else begin
            if (state == LAST) begin
                wr_idx <= '0;
                rd_idx <= '0;
            end else if (capture) begin
                wr_idx <= last_capture ? '0 : wr_idx + IDX_W'(1);
            end
            if ((state == DRAIN) && m_ready) begin
                rd_idx <= rd_is_last ? '0 : rd_idx + IDX_W'(1);
            end
            if (final_fire) begin
                msg_count <= msg_count + 16'd1;
            end
        end
    end

    // Digest buffer holds data only; it is overwritten per message, never cleared.
    always_ff @(posedge clk) begin
        if (capture) begin
            digest_buf[wr_idx] <= core_dout;
        end
    end

endmodule

// File: tb/tb_keccak_msg_sequencer.sv
// Testbench for keccak_msg_sequencer: table of directed messages plus
// hand-written sequences for reset abort, back-to-back start and the
// WAIT_READY watchdog (or indefinite wait when the watchdog is disabled).

module tb_keccak_msg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_data;
    logic        s_valid, s_end, s_ready;
    logic        core_start, core_din_valid, core_last_block;
    logic [63:0] core_din;
    logic        core_buffer_full, core_ready, core_dout_valid;
    logic [63:0] core_dout;
    logic [63:0] m_data;
    logic        m_valid, m_ready, m_last;
    logic        busy, done, err;
    logic [15:0] msg_count;

    always #5 clk = ~clk;

    keccak_msg_sequencer #(
        .W(64), .DIGEST_WORDS(4), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_end(s_end), .s_ready(s_ready),
        .core_start(core_start), .core_din(core_din), .core_din_valid(core_din_valid),
        .core_last_block(core_last_block), .core_buffer_full(core_buffer_full),
        .core_ready(core_ready), .core_dout(core_dout), .core_dout_valid(core_dout_valid),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .busy(busy), .done(done), .msg_count(msg_count), .err(err)
    );

    typedef struct {
        int              nw;
        logic [2:0][63:0] w;
        int              full_at;
        bit              mstall;
        bit              surplus;
        logic [3:0][63:0] dig;
    } vec_t;

    vec_t vt [4];

    int n_vec = 0;
    int n_err = 0;
    int exp_count = 0;

    // Event log sampled at the falling edge, where handshakes are stable.
    logic [63:0] din_log [256];
    int din_n = 0, start_n = 0, lastb_n = 0, done_n = 0;
    int b_din, b_start, b_lastb, b_done;

    always @(negedge clk) begin
        if (core_din_valid) begin
            din_log[din_n[7:0]] <= core_din;
            din_n <= din_n + 1;
        end
        if (core_start)      start_n <= start_n + 1;
        if (core_last_block) lastb_n <= lastb_n + 1;
        if (done)            done_n  <= done_n + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
        $fatal(1, "global timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap();
        b_din   = din_n;
        b_start = start_n;
        b_lastb = lastb_n;
        b_done  = done_n;
    endtask

    function automatic vec_t mk(input int nw, input logic [63:0] w0, w1, w2,
                                input int full_at, input bit mstall, input bit surplus,
                                input logic [63:0] d0, d1, d2, d3);
        vec_t v;
        v.nw = nw;
        v.w[0] = w0; v.w[1] = w1; v.w[2] = w2;
        v.full_at = full_at;
        v.mstall = mstall;
        v.surplus = surplus;
        v.dig[0] = d0; v.dig[1] = d1; v.dig[2] = d2; v.dig[3] = d3;
        return v;
    endfunction

    // Present one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [63:0] data, input logic endf);
        bit acc = 0;
        s_valid = 1'b1;
        s_data  = data;
        s_end   = endf;
        for (int n = 0; n < 100 && !acc; n++) begin
            @(negedge clk);
            acc = s_ready;
            tick();
        end
        if (!acc) check("beat_accept_timeout", 0, 1);
        s_valid = 1'b0;
        s_end   = 1'b0;
    endtask

    task automatic feed_msg(input vec_t v);
        int bad;
        snap();
        for (int k = 0; k < v.nw; k++) begin
            if (k == v.full_at) begin
                core_buffer_full = 1'b1;
                s_valid = 1'b1;
                s_data  = v.w[k];
                bad = 0;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    if (s_ready !== 1'b0 || core_din_valid !== 1'b0) bad++;
                    tick();
                end
                check("full_stall_blocks", 64'(bad), 0);
                core_buffer_full = 1'b0;
            end
            send_beat(v.w[k], 1'b0);
        end
        send_beat(64'hDEAD_BEEF_DEAD_BEEF, 1'b1);
    endtask

    task automatic wait_last_block(output bit got);
        got = 0;
        for (int n = 0; n < 60 && !got; n++) begin
            @(negedge clk);
            got = core_last_block;
            if (!got) @(posedge clk);
        end
        check("last_block_seen", 64'(got), 1);
        tick();   // now in COLLECT
    endtask

    task automatic finish_msg(input vec_t v, input bit chain);
        bit got;
        int bad;
        wait_last_block(got);
        if (!got) return;
        // Four digest words with one idle cycle in the middle.
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                core_dout_valid = 1'b0;
                core_dout = 64'hF00D;
                tick();
            end
            core_dout = v.dig[k];
            core_dout_valid = 1'b1;
            tick();
        end
        core_dout_valid = 1'b0;
        m_ready = 1'b0;
        @(negedge clk);
        check("m_valid_one_cycle_after_capture", 64'(m_valid), 1);
        if (v.mstall) begin
            bad = 0;
            for (int c = 0; c < 10; c++) begin
                tick();
                core_dout_valid = v.surplus && (c % 3 == 0);
                core_dout = 64'hBAD0_0000 + 64'(c);
                @(negedge clk);
                if (m_valid !== 1'b1 || m_data !== v.dig[0] || m_last !== 1'b0) bad++;
            end
            check("drain_stall_stable", 64'(bad), 0);
        end
        tick();
        core_dout_valid = 1'b0;
        m_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("m_data[%0d]", k), m_data, v.dig[k]);
            check($sformatf("m_last[%0d]", k), {m_valid, m_last}, {1'b1, (k == 3)});
            check($sformatf("done[%0d]", k), 64'(done), 64'(k == 3));
            if (chain && k == 3) begin
                s_valid = 1'b1;
                s_end   = 1'b1;
            end
            tick();
        end
        m_ready = 1'b0;
        exp_count++;
        @(negedge clk);
        check("busy_after_done", 64'(busy), 0);
        check("msg_count", 64'(msg_count), 64'(exp_count));
        check("start_pulses", 64'(start_n - b_start), 1);
        check("last_block_pulses", 64'(lastb_n - b_lastb), 1);
        check("done_pulses", 64'(done_n - b_done), 1);
        check("din_beats", 64'(din_n - b_din), 64'(v.nw));
        for (int k = 0; k < v.nw && k < din_n - b_din; k++)
            check($sformatf("din_word[%0d]", k), din_log[8'(b_din + k)], v.w[k]);
        check("err_clear", 64'(err), 0);
    endtask

    initial begin
        bit got;
        int bad;
        rst = 1'b1;
        s_data = '0; s_valid = 1'b0; s_end = 1'b0;
        core_buffer_full = 1'b0; core_ready = 1'b1;
        core_dout = '0; core_dout_valid = 1'b0;
        m_ready = 1'b0;

        vt[0] = mk(3, 64'h1, 64'h2, 64'h3, -1, 0, 0,
                   64'hA000_0000_0000_0000, 64'hA111_0000_0000_0001,
                   64'hA222_0000_0000_0002, 64'hA333_0000_0000_0003);
        vt[1] = mk(3, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                   64'h3333_3333_3333_3333, 1, 0, 0,
                   64'hB0, 64'hB1, 64'hB2, 64'hB3);
        vt[2] = mk(0, 64'h0, 64'h0, 64'h0, -1, 0, 0,
                   64'hC0C0, 64'hC1C1, 64'hC2C2, 64'hC3C3);
        vt[3] = mk(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001, 64'h0, -1, 1, 1,
                   64'hD000_0000_0000_00D0, 64'hD1, 64'hD2, 64'hFFFF_FFFF_FFFF_FFFF);

        // Reset state
        s_valid = 1'b1;   // must not be accepted during reset
        tick(); tick();
        @(negedge clk);
        check("outputs_in_reset",
              {s_ready, core_start, core_din_valid, core_last_block, |core_din,
               m_valid, m_last, busy, done}, 0);
        tick();
        rst = 1'b0;
        s_valid = 1'b0;
        @(negedge clk);
        check("idle_outputs",
              {s_ready, core_start, core_din_valid, core_last_block, m_valid, m_last, busy, done}, 0);
        check("msg_count_reset", 64'(msg_count), 0);
        check("err_reset", 64'(err), 0);
        tick();

        // Table-driven messages
        for (int i = 0; i < 4; i++) begin
            feed_msg(vt[i]);
            finish_msg(vt[i], 1'b0);
        end

        // Back-to-back: a beat waiting at the final handshake starts the next message.
        feed_msg(vt[0]);
        finish_msg(vt[0], 1'b1);
        snap();
        tick();
        @(negedge clk);
        check("chained_core_start", 64'(core_start), 1);
        tick();
        send_beat(64'h0, 1'b1);
        finish_msg(vt[2], 1'b0);

        // Reset during COLLECT aborts without done
        feed_msg(vt[0]);
        wait_last_block(got);
        core_dout = 64'h5555; core_dout_valid = 1'b1;
        tick(); tick();
        rst = 1'b1;
        core_dout_valid = 1'b0;
        @(negedge clk);
        check("outputs_during_collect_reset",
              {s_ready, core_start, core_din_valid, core_last_block, |core_din,
               m_valid, m_last, busy, done}, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("outputs_after_collect_reset",
              {s_ready, core_start, core_din_valid, core_last_block, |core_din,
               m_valid, m_last, busy, done}, 0);
        check("msg_count_after_reset", 64'(msg_count), 0);
        exp_count = 0;
        tick();
        feed_msg(vt[1]);
        finish_msg(vt[1], 1'b0);

        // Core never ready
        snap();
        core_ready = 1'b0;
        send_beat(64'h0, 1'b1);   // now in first WAIT_READY cycle
`ifdef KECCAK_SEQ_TIMEOUT_EN
        bad = 0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || err !== 1'b0) bad++;
            tick();
        end
        check("wait_before_timeout", 64'(bad), 0);
        @(negedge clk);
        check("timeout_err", 64'(err), 1);
        check("timeout_idle", 64'(busy), 0);
        check("timeout_no_done", 64'(done_n - b_done), 0);
        check("timeout_no_last_block", 64'(lastb_n - b_lastb), 0);
        check("timeout_msg_count", 64'(msg_count), 64'(exp_count));
        core_ready = 1'b1;
        tick(); tick();
        @(negedge clk);
        check("err_sticky", 64'(err), 1);
`else
        bad = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (busy !== 1'b1 || err !== 1'b0 || core_last_block !== 1'b0) bad++;
            tick();
        end
        check("wait_indefinitely", 64'(bad), 0);
        core_ready = 1'b1;
        finish_msg(vt[2], 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/keccak_msg_sequencer.md
KECCAK_MSG_SEQUENCER -- requirements
Module: keccak_msg_sequencer

Interface
REQ-001 SHALL have parameter W, default 64: width of message and digest words.
REQ-002 SHALL have parameter DIGEST_WORDS, default 4, legal range 1..8: number of core output words collected per message.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 4096, max 65535: watchdog limit, used only under KECCAK_SEQ_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all logic on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 s_data  in  W  message word.
REQ-007 s_valid  in  1  upstream beat valid.
REQ-008 s_end  in  1  beat is the end-of-message terminator; s_data is ignored on that beat.
REQ-009 s_ready  out  1  upstream beat accepted when s_valid & s_ready.
REQ-010 core_start, core_din[W], core_din_valid, core_last_block  out  drive the keccak core.
REQ-011 core_buffer_full, core_ready, core_dout[W], core_dout_valid  in  from the keccak core.
REQ-012 m_data  out  W  digest word; m_valid  out  1; m_ready  in  1; m_last  out  1, set on the final digest word.
REQ-013 busy  out  1  high in every state except IDLE; done  out  1  one-cycle pulse on the final digest handshake.
REQ-014 msg_count  out  16  number of completed messages, wraps at 65535->0; err  out  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, START, GAP, FEED, WAIT_READY, LAST, COLLECT, DRAIN.
REQ-016 IDLE: s_ready=0; when s_valid=1, go to START without consuming the beat.
REQ-017 START: core_start=1 for exactly one cycle, then GAP; GAP: one cycle with all core controls 0, then FEED.
REQ-018 FEED: s_ready = !core_buffer_full; core_din = s_data; core_din_valid = s_valid & s_ready & !s_end, combinational.
REQ-019 FEED: an accepted beat with s_end=1 SHALL go to WAIT_READY and SHALL NOT assert core_din_valid.
REQ-020 Zero-length message: a first beat with s_end=1 SHALL be valid and produce START, GAP, FEED, WAIT_READY with no data words.
REQ-021 WAIT_READY: at least one cycle; leave to LAST on the first cycle after entry sampling core_ready=1 and core_buffer_full=0.
REQ-022 LAST: core_last_block=1 for exactly one cycle, then COLLECT with write index 0.
REQ-023 COLLECT: each cycle with core_dout_valid=1 SHALL store core_dout at the write index and increment it; after DIGEST_WORDS captures, go to DRAIN.
REQ-024 core_dout_valid outside COLLECT, and any surplus beats, SHALL be ignored.
REQ-025 DRAIN: m_valid=1, m_data=buffer[read index], m_last=1 when the read index = DIGEST_WORDS-1; advance on m_valid & m_ready; m_data stable while stalled.
REQ-026 On the final DRAIN handshake: done=1 for that cycle, msg_count+1, next state IDLE; a waiting s_valid starts a new message on the next cycle.
REQ-027 Latency from the LAST cycle to the first m_valid SHALL be the core latency plus exactly 1 cycle.

Reset
REQ-028 When rst=1 at a clock edge: state=IDLE, read and write indices 0, msg_count=0, err=0; the digest buffer is not cleared.
REQ-029 During and after reset, all outputs SHALL be 0: s_ready, core_*, m_valid, m_last, busy, done.
REQ-030 A reset in any state SHALL abort the message without a done pulse. The integrator SHALL reset the core concurrently (core rst_n = !rst).

Configuration
REQ-031 Macro KECCAK_SEQ_TIMEOUT_EN defined: a 16-bit watchdog SHALL count cycles spent in WAIT_READY plus COLLECT, clearing on entry to WAIT_READY.
REQ-032 With the macro, reaching TIMEOUT_CYCLES SHALL set err=1 (sticky until rst), discard the partial digest, go to IDLE with no done, and leave msg_count unchanged.
REQ-033 Without the macro: no watchdog logic; err tied 0; WAIT_READY and COLLECT wait indefinitely.

Verification
REQ-034 Three words 0x1,0x2,0x3 then s_end, no backpressure -> exactly three core_din_valid beats in order; one core_last_block pulse; 4 digest words on m_data; m_last on the 4th; done; msg_count=1.
REQ-035 core_buffer_full held 1 for 5 cycles mid-message -> s_ready=0 and core_din_valid=0 for those cycles; no word lost or duplicated.
REQ-036 Zero-length message (s_end only) -> core_start, zero din beats, core_last_block, 4 digest words delivered.
REQ-037 m_ready=0 for 10 cycles during DRAIN -> m_data and m_valid stable; core_dout_valid pulses during DRAIN ignored.
REQ-038 rst asserted during COLLECT -> next cycle all outputs 0 and busy=0; the following message completes normally with msg_count=1.
REQ-039 With KECCAK_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, core_ready held 0 -> err=1 after 16 WAIT_READY cycles; state IDLE; no done; msg_count unchanged.
